// File: rtl/var_fork_top.sv
// var_fork_top: splits each {zero_mean_data, variance} beat into two independently drained FIFO branches,
// tagging the data branch with a row-end TLAST.
module var_fork_top #(
  parameter int DATA_W    = 128,
  parameter int VAR_W     = 16,
  parameter int DEPTH     = 4,
  parameter int ROW_BEATS = 8
)(
  input  logic                    aclk,
  input  logic                    arstn,
  input  logic [DATA_W+VAR_W-1:0] S_AXIS_TDATA,
  input  logic                    S_AXIS_TVALID,
  output logic                    S_AXIS_TREADY,
  output logic [DATA_W-1:0]       M_AXIS_0_TDATA,
  output logic                    M_AXIS_0_TVALID,
  input  logic                    M_AXIS_0_TREADY,
  output logic                    M_AXIS_0_TLAST,
  output logic [VAR_W-1:0]        M_AXIS_1_TDATA,
  output logic                    M_AXIS_1_TVALID,
  input  logic                    M_AXIS_1_TREADY
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = ROW_BEATS > 1 ? $clog2(ROW_BEATS) : 1;
  logic [DATA_W:0]    mem0 [DEPTH];
  logic [VAR_W-1:0]   mem1 [DEPTH];
  logic [AW-1:0]      wp0, rp0, wp1, rp1;
  logic [CW-1:0]      cnt0, cnt1;
  logic [BW-1:0]      beat;
  logic               wr, rd0, rd1, last_in;
  assign S_AXIS_TREADY   = arstn && cnt0 < CW'(DEPTH) && cnt1 < CW'(DEPTH);
  assign wr              = S_AXIS_TVALID && S_AXIS_TREADY;
  assign last_in         = beat == BW'(ROW_BEATS - 1);
  assign M_AXIS_0_TVALID = cnt0 != '0;
  assign M_AXIS_1_TVALID = cnt1 != '0;
  assign rd0             = M_AXIS_0_TVALID && M_AXIS_0_TREADY;
  assign rd1             = M_AXIS_1_TVALID && M_AXIS_1_TREADY;
  assign M_AXIS_0_TDATA  = mem0[rp0][DATA_W-1:0];
  // Stale memory may hold a 1 in the TLAST bit, so gate it while the branch is empty
  assign M_AXIS_0_TLAST  = mem0[rp0][DATA_W] && M_AXIS_0_TVALID;
  assign M_AXIS_1_TDATA  = mem1[rp1];
  always_ff @(posedge aclk)
    if (wr) begin
      mem0[wp0] <= {last_in, S_AXIS_TDATA[DATA_W+VAR_W-1:VAR_W]};
      mem1[wp1] <= S_AXIS_TDATA[VAR_W-1:0];
    end
  always_ff @(posedge aclk or negedge arstn)
    if (!arstn) begin
      wp0  <= '0;
      rp0  <= '0;
      wp1  <= '0;
      rp1  <= '0;
      cnt0 <= '0;
      cnt1 <= '0;
      beat <= '0;
    end else begin
      wp0  <= wr ? wp0 + AW'(1) : wp0;
      wp1  <= wr ? wp1 + AW'(1) : wp1;
      beat <= wr ? (last_in ? '0 : beat + BW'(1)) : beat;
      rp0  <= rd0 ? rp0 + AW'(1) : rp0;
      rp1  <= rd1 ? rp1 + AW'(1) : rp1;
      cnt0 <= cnt0 + CW'(wr) - CW'(rd0);
      cnt1 <= cnt1 + CW'(wr) - CW'(rd1);
    end
endmodule

// File: tb/tb_var_fork_top.sv
// tb_var_fork_top: directed table, corner-case sequences and a randomized scoreboard run for var_fork_top.
module tb_var_fork_top;
  localparam int DW = 128;
  localparam int VW = 16;
  logic          aclk = 1'b0;
  logic          arstn = 1'b0;
  logic [DW+VW-1:0] s_data = '0;
  logic          s_valid = 1'b0, r0 = 1'b0, r1 = 1'b0;
  logic          s_ready, v0, v1, last;
  logic [DW-1:0] d0;
  logic [VW-1:0] d1;
  logic          one_ready, one_v0, one_v1, one_last;
  logic [DW-1:0] one_d0;
  logic [VW-1:0] one_d1;
  int n_chk = 0, n_fail = 0;
  always #5 aclk = ~aclk;
  var_fork_top dut (
    .aclk(aclk), .arstn(arstn),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(s_ready),
    .M_AXIS_0_TDATA(d0), .M_AXIS_0_TVALID(v0), .M_AXIS_0_TREADY(r0), .M_AXIS_0_TLAST(last),
    .M_AXIS_1_TDATA(d1), .M_AXIS_1_TVALID(v1), .M_AXIS_1_TREADY(r1)
  );
  var_fork_top #(.ROW_BEATS(1)) one (
    .aclk(aclk), .arstn(arstn),
    .S_AXIS_TDATA(s_data), .S_AXIS_TVALID(s_valid), .S_AXIS_TREADY(one_ready),
    .M_AXIS_0_TDATA(one_d0), .M_AXIS_0_TVALID(one_v0), .M_AXIS_0_TREADY(r0), .M_AXIS_0_TLAST(one_last),
    .M_AXIS_1_TDATA(one_d1), .M_AXIS_1_TVALID(one_v1), .M_AXIS_1_TREADY(r1)
  );
  typedef struct {
    logic v; int i; logic a, b;
    logic e_rdy, e_v0, e_v1; int e_h0, e_h1; logic e_last;
  } vec_t;
  vec_t tbl [11];
  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  function automatic logic [DW-1:0] pd(input int i);
    return {16{i[7:0]}};
  endfunction
  function automatic logic [VW-1:0] pv(input int i);
    return 16'h3F00 + i[15:0];
  endfunction
  task automatic step;
    @(posedge aclk);
    #1;
  endtask
  task automatic drive(input logic v, input int i, input logic a, input logic b);
    s_valid = v;
    s_data  = {pd(i), pv(i)};
    r0      = a;
    r1      = b;
  endtask
  logic [DW:0]   q0 [$];
  logic [VW-1:0] q1 [$];
  logic          exp_rdy;
  int bc, sent, cyc;
  initial begin
    tbl[0]  = '{1'b1, 1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[1]  = '{1'b1, 2, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[2]  = '{1'b1, 3, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[3]  = '{1'b1, 4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1, 1, 1'b0};
    tbl[4]  = '{1'b1, 5, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2, 2, 1'b0};
    tbl[5]  = '{1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2, 2, 1'b0};
    tbl[6]  = '{1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3, 2, 1'b0};
    tbl[7]  = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4, 3, 1'b0};
    tbl[8]  = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5, 4, 1'b0};
    tbl[9]  = '{1'b0, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 0, 5, 1'b0};
    tbl[10] = '{1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 1'b0};
    #12;
    chk("rst_ready", s_ready, 0);
    chk("rst_v0", v0, 0);
    chk("rst_v1", v1, 0);
    chk("rst_last", last, 0);
    arstn = 1'b1;
    step;
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_v0", v0, 0);
    // Fill to full, then read both and offer a beat in the same cycle: it must wait a cycle
    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].i, tbl[k].a, tbl[k].b);
      step;
      chk($sformatf("tbl%0d_ready", k), s_ready, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_v0", k), v0, tbl[k].e_v0);
      chk($sformatf("tbl%0d_v1", k), v1, tbl[k].e_v1);
      if (tbl[k].e_v0) chk($sformatf("tbl%0d_d0", k), d0, pd(tbl[k].e_h0));
      if (tbl[k].e_v1) chk($sformatf("tbl%0d_d1", k), d1, pv(tbl[k].e_h1));
      chk($sformatf("tbl%0d_last", k), last, tbl[k].e_last);
      chk($sformatf("tbl%0d_one_last", k), one_last, tbl[k].e_v0);
    end
    s_valid = 1'b1;
    s_data  = {128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 16'h3F80};
    r0 = 1'b1;
    r1 = 1'b1;
    step;
    chk("single_v0", v0, 1);
    chk("single_d0", d0, 128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF);
    chk("single_v1", v1, 1);
    chk("single_d1", d1, 16'h3F80);
    s_valid = 1'b0;
    step;
    chk("single_v0_gone", v0, 0);
    chk("single_v1_gone", v1, 0);
    // Variance branch stalled: data keeps flowing until the variance FIFO fills
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 10 + k, 1'b1, 1'b0);
      step;
      chk($sformatf("stall%0d_v0", k), v0, 1);
      chk($sformatf("stall%0d_d0", k), d0, pd(10 + k));
      chk($sformatf("stall%0d_last", k), last, k == 1);
      chk($sformatf("stall%0d_ready", k), s_ready, k < 3);
      chk($sformatf("stall%0d_d1", k), d1, pv(10));
    end
    drive(1'b1, 14, 1'b1, 1'b0);
    step;
    chk("stall4_v0", v0, 0);
    chk("stall4_ready", s_ready, 0);
    drive(1'b1, 14, 1'b1, 1'b1);
    step;
    chk("release_ready", s_ready, 1);
    chk("release_v0", v0, 0);
    chk("release_d1", d1, pv(11));
    step;
    chk("release_d0a", d0, pd(14));
    chk("release_d1a", d1, pv(12));
    drive(1'b1, 15, 1'b1, 1'b1);
    step;
    chk("release_d0b", d0, pd(15));
    chk("release_d1b", d1, pv(13));
    drive(1'b0, 0, 1'b1, 1'b1);
    step;
    chk("release_v0_empty", v0, 0);
    chk("release_d1c", d1, pv(14));
    step;
    chk("release_d1d", d1, pv(15));
    step;
    chk("release_v1_empty", v1, 0);
    // Asynchronous reset pulse with three beats buffered
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 20 + k, 1'b0, 1'b0);
      step;
    end
    chk("prerst_v0", v0, 1);
    s_valid = 1'b0;
    #2 arstn = 1'b0;
    #1;
    chk("midrst_v0", v0, 0);
    chk("midrst_v1", v1, 0);
    chk("midrst_ready", s_ready, 0);
    chk("midrst_last", last, 0);
    chk("midrst_one_last", one_last, 0);
    #1 arstn = 1'b1;
    step;
    chk("afterrst_ready", s_ready, 1);
    chk("afterrst_v0", v0, 0);
    chk("afterrst_v1", v1, 0);
    for (int n = 1; n <= 24; n++) begin
      drive(1'b1, 100 + n, 1'b1, 1'b1);
      step;
      chk($sformatf("row%0d_d0", n), d0, pd(100 + n));
      chk($sformatf("row%0d_d1", n), d1, pv(100 + n));
      chk($sformatf("row%0d_last", n), last, n % 8 == 0);
    end
    drive(1'b0, 0, 1'b1, 1'b1);
    step;
    chk("row_drained", v0, 0);
    bc = 0;
    sent = 0;
    cyc = 0;
    while (sent < 10000 && cyc < 60000) begin
      s_valid = $urandom_range(0, 3) != 0;
      s_data  = {$urandom(), $urandom(), $urandom(), $urandom(), 16'($urandom())};
      r0 = $urandom_range(0, 3) != 0;
      r1 = $urandom_range(0, 3) != 0;
      exp_rdy = q0.size() < 4 && q1.size() < 4;
      chk("rnd_ready", s_ready, exp_rdy);
      chk("rnd_v0", v0, q0.size() != 0);
      chk("rnd_v1", v1, q1.size() != 0);
      if (r0 && q0.size() != 0) chk("rnd_d0", {last, d0}, q0.pop_front());
      if (r1 && q1.size() != 0) chk("rnd_d1", d1, q1.pop_front());
      if (s_valid && exp_rdy) begin
        q0.push_back({bc == 7, s_data[DW+VW-1:VW]});
        q1.push_back(s_data[VW-1:0]);
        bc = (bc + 1) % 8;
        sent++;
      end
      step;
      cyc++;
    end
    s_valid = 1'b0;
    r0 = 1'b1;
    r1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (q0.size() != 0) chk("drain_d0", {last, d0}, q0.pop_front());
      if (q1.size() != 0) chk("drain_d1", d1, q1.pop_front());
      step;
    end
    chk("rnd_sent", sent, 10000);
    chk("rnd_end_v0", v0, 0);
    chk("rnd_end_v1", v1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/var_fork_top.md
VAR_FORK_TOP -- requirements
Module: var_fork_top

Interface
REQ-001 Parameter DATA_W, default 128, zero-mean data width per beat (8 bf16 lanes).
REQ-002 Parameter VAR_W, default 16, bf16 variance width.
REQ-003 Parameter DEPTH, default 4, entries per branch FIFO; power of two, at least 2.
REQ-004 Parameter ROW_BEATS, default 8, input beats per row, at least 1.
REQ-005 Port aclk, input, 1, sole clock; all logic on the rising edge.
REQ-006 Port arstn, input, 1, asynchronous active-low reset.
REQ-007 Port S_AXIS_TDATA, input, DATA_W+VAR_W, packed as {zero_mean_data[143:16], variance[15:0]}.
REQ-008 Port S_AXIS_TVALID, input, 1, input beat valid.
REQ-009 Port S_AXIS_TREADY, output, 1, input beat accepted when high with TVALID.
REQ-010 Port M_AXIS_0_TDATA, output, DATA_W, zero-mean data branch.
REQ-011 Port M_AXIS_0_TVALID, output, 1, data branch valid.
REQ-012 Port M_AXIS_0_TREADY, input, 1, data branch ready.
REQ-013 Port M_AXIS_0_TLAST, output, 1, high on the last beat of each row.
REQ-014 Port M_AXIS_1_TDATA, output, VAR_W, variance branch.
REQ-015 Port M_AXIS_1_TVALID, output, 1, variance branch valid.
REQ-016 Port M_AXIS_1_TREADY, input, 1, variance branch ready.

Function
REQ-017 The block SHALL split each accepted input beat into one data-branch entry ({TLAST, S_AXIS_TDATA[143:16]}) and one variance-branch entry (S_AXIS_TDATA[15:0]), written in the same cycle.
REQ-018 Each branch SHALL have its own DEPTH-entry circular FIFO with read pointer, write pointer and occupancy count; pointers wrap from DEPTH-1 to 0.
REQ-019 S_AXIS_TREADY SHALL equal (data count < DEPTH) AND (variance count < DEPTH) AND reset released; it SHALL NOT depend on S_AXIS_TVALID.
REQ-020 An input handshake SHALL be S_AXIS_TVALID and S_AXIS_TREADY high on a rising edge; it writes both FIFOs, and it never writes only one.
REQ-021 M_AXIS_n_TVALID SHALL equal (branch count != 0); M_AXIS_n_TDATA and TLAST SHALL come from the entry at that branch's read pointer.
REQ-022 Latency SHALL be 1 cycle: a beat accepted at edge k SHALL be visible on both outputs after edge k if that branch was empty.
REQ-023 Each branch SHALL drain independently on its own TVALID and TREADY handshake; a stalled branch SHALL NOT stall the other until its FIFO is full.
REQ-024 Output TDATA and TLAST SHALL hold stable while TVALID is high and TREADY is low.
REQ-025 A simultaneous write and read on a non-full, non-empty branch SHALL leave its count unchanged; on an empty branch, only the write takes effect that cycle.
REQ-026 With a branch full, S_AXIS_TREADY SHALL be low even if that branch is read in the same cycle; there is no full-cycle pass-through.
REQ-027 A beat counter SHALL count input handshakes 0..ROW_BEATS-1; TLAST written for a beat SHALL be 1 iff the counter equals ROW_BEATS-1, after which the counter wraps to 0.
REQ-028 With ROW_BEATS=1, every beat SHALL carry TLAST=1.
REQ-029 Data SHALL be passed bit-exact; the block performs no arithmetic on the bf16 fields.

Reset
REQ-030 arstn low SHALL asynchronously clear all pointers, counts and the beat counter.
REQ-031 While arstn is low, S_AXIS_TREADY, M_AXIS_0_TVALID, M_AXIS_1_TVALID and M_AXIS_0_TLAST SHALL all be 0.
REQ-032 After arstn deasserts, S_AXIS_TREADY SHALL be 1 from the first rising edge onward.
REQ-033 Reset asserted mid-operation SHALL discard all buffered entries and restart the row count at beat 0; FIFO memory contents need no reset.

Verification
REQ-034 Single beat: send 144'h{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF,16'h3F80} with both TREADY=1 -> next cycle M0=128'h0011...EEFF, M1=16'h3F80, both valid for exactly 1 cycle.
REQ-035 Branch stall: M_AXIS_1_TREADY=0, M_AXIS_0_TREADY=1, stream 6 beats -> M0 delivers all beats as they arrive; S_AXIS_TREADY drops after the 4th accepted beat; releasing M_AXIS_1_TREADY yields variances in order.
REQ-036 Full boundary: both TREADY=0, 4 beats accepted -> S_AXIS_TREADY=0; one read on each branch plus TVALID in the same cycle -> no accept that cycle, accept on the next cycle.
REQ-037 TLAST: ROW_BEATS=8, stream 20 beats -> TLAST high on data beats 8 and 16 only, and the counter is at 4 afterward.
REQ-038 Reset mid-stream: 3 beats buffered, pulse arstn low asynchronously between edges -> both TVALID drop immediately; after release, the next beat's TLAST position restarts the count at beat 0.
REQ-039 Random: random TVALID and per-branch TREADY over 10000 beats -> both outputs equal the scoreboard, with no loss, duplication or reorder.
